ru_allocator: RTL and testbench

Assigns the NUM_RU redundant recompute units (RUs) of the BISR systolic array to faulty PEs. It scans the PE fault matrix produced by self-test (STW) one PE per cycle and builds a registered RU→(row,col) mapping table. The datapath uses the table to reroute faulty PE work, and it is exposed through a lookup port. It sits between the STW result and the recompute-unit steering logic in the array top level.

---
 rtl/bisr_pkg.sv | 18 +
 rtl/ru_allocator_lookup.sv | 41 ++++
 rtl/ru_allocator.sv | 164 ++++++++++++++++
 tb/tb_ru_allocator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// Shared types and width helpers for the BISR redundant-unit allocation logic.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package bisr_pkg;

  // Allocation pass states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } alloc_state_t;

  // Index width that never collapses to zero bits for single-entry dimensions
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ru_allocator_lookup.sv
// Combinational lookup of a PE coordinate in the RU mapping table.
// Latency: zero cycles; result follows table registers and query inputs directly.
// Backpressure: none; the lookup is gated off while an allocation pass is running.
module ru_lookup
  import bisr_pkg::*;
#(
  parameter int NUM_RU = 4,
  parameter int RW     = 2,
  parameter int CW     = 2,
  parameter int UW     = 2
) (
  input  logic                 busy,
  input  logic [NUM_RU-1:0]    ru_valid,
  input  logic [NUM_RU*RW-1:0] ru_row,
  input  logic [NUM_RU*CW-1:0] ru_col,
  input  logic [RW-1:0]        query_row,
  input  logic [CW-1:0]        query_col,
  output logic                 query_hit,
  output logic [UW-1:0]        query_ru
);

  // Priority match: scan from the top so the lowest matching index is the last writer
  always_comb begin
    query_hit = 1'b0;
    query_ru  = '0;
    for (int k = NUM_RU - 1; k >= 0; k--) begin
      if (ru_valid[k] &&
          (ru_row[k*RW +: RW] == query_row) &&
          (ru_col[k*CW +: CW] == query_col)) begin
        query_hit = 1'b1;
        query_ru  = UW'(k);
      end
    end
    // The table is half-built during a pass, so it is not offered to consumers
    if (busy) begin
      query_hit = 1'b0;
      query_ru  = '0;
    end
  end

endmodule

// File: rtl/ru_allocator.sv
// Scans a snapshot of the PE fault matrix column-major and maps faulty PEs onto redundant units.
// Latency: ROWS*COLS+1 cycles from accepted start to the done pulse; table entries visible one cycle after write.
// Backpressure: start is only honoured in IDLE; starts during a pass are dropped, not queued.
module ru_allocator
  import bisr_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4,
  localparam int RW    = clog2_min1(ROWS),
  localparam int CW    = clog2_min1(COLS),
  localparam int UW    = clog2_min1(NUM_RU),
  localparam int NW    = $clog2(ROWS*COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] fault_mat,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_RU-1:0]    ru_valid,
  output logic [NUM_RU*RW-1:0] ru_row,
  output logic [NUM_RU*CW-1:0] ru_col,
  output logic [NW-1:0]        fault_count,
  output logic                 overflow,
  input  logic [RW-1:0]        query_row,
  input  logic [CW-1:0]        query_col,
  output logic                 query_hit,
  output logic [UW-1:0]        query_ru
);

  localparam int NPE = ROWS * COLS;
  localparam int IW  = clog2_min1(NPE);

  localparam logic [IW-1:0] IDX_LAST = IW'(NPE - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
  localparam logic [UW:0]   PTR_FULL = (UW+1)'(NUM_RU);
  localparam logic [NW-1:0] CNT_MAX  = NW'(NPE);

  alloc_state_t         state_q;
  logic                 busy_q;
  logic                 done_q;
  logic [NPE-1:0]       snap_q;
  logic [RW-1:0]        r_q;
  logic [CW-1:0]        c_q;
  // Flat bit index kept alongside (r,c) so the snapshot is addressed without a multiplier
  logic [IW-1:0]        idx_q;
  // One extra bit so "all RUs taken" is a distinct value
  logic [UW:0]          alloc_ptr_q;
  logic [NUM_RU-1:0]    ru_valid_q;
  logic [NUM_RU*RW-1:0] ru_row_q;
  logic [NUM_RU*CW-1:0] ru_col_q;
  logic [NW-1:0]        fault_count_q;
  logic                 overflow_q;

  // Allocation FSM, scan counters and mapping table, all with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      snap_q        <= '0;
      r_q           <= '0;
      c_q           <= '0;
      idx_q         <= '0;
      alloc_ptr_q   <= '0;
      ru_valid_q    <= '0;
      ru_row_q      <= '0;
      ru_col_q      <= '0;
      fault_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Freeze the matrix so later changes cannot disturb this pass
            snap_q        <= fault_mat;
            r_q           <= '0;
            c_q           <= '0;
            idx_q         <= '0;
            alloc_ptr_q   <= '0;
            ru_valid_q    <= '0;
            ru_row_q      <= '0;
            ru_col_q      <= '0;
            fault_count_q <= '0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= SCAN;
          end
        end

        SCAN: begin
          if (snap_q[idx_q]) begin
            if (fault_count_q != CNT_MAX) begin
              fault_count_q <= fault_count_q + 1'b1;
            end
            if (alloc_ptr_q < PTR_FULL) begin
              for (int k = 0; k < NUM_RU; k++) begin
                if (alloc_ptr_q == (UW+1)'(k)) begin
                  ru_valid_q[k]          <= 1'b1;
                  ru_row_q[k*RW +: RW]   <= r_q;
                  ru_col_q[k*CW +: CW]   <= c_q;
                end
              end
              alloc_ptr_q <= alloc_ptr_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
          end

          // Column-major walk: rows fastest, carry into the column counter
          if (r_q == R_LAST) begin
            r_q <= '0;
            c_q <= c_q + 1'b1;
          end else begin
            r_q <= r_q + 1'b1;
          end
          idx_q <= idx_q + 1'b1;

          if (idx_q == IDX_LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ru_valid    = ru_valid_q;
  assign ru_row      = ru_row_q;
  assign ru_col      = ru_col_q;
  assign fault_count = fault_count_q;
  assign overflow    = overflow_q;

  ru_lookup #(
    .NUM_RU (NUM_RU),
    .RW     (RW),
    .CW     (CW),
    .UW     (UW)
  ) u_lookup (
    .busy      (busy_q),
    .ru_valid  (ru_valid_q),
    .ru_row    (ru_row_q),
    .ru_col    (ru_col_q),
    .query_row (query_row),
    .query_col (query_col),
    .query_hit (query_hit),
    .query_ru  (query_ru)
  );

endmodule

// File: tb/tb_ru_allocator.sv
// Directed bench for ru_allocator with a scoreboard of expected mapping tables.
// Expected tables are built from the fault matrix when a pass is started and checked at done.
// Ends with a single CHECKS/ERRORS summary line.
module tb_ru_allocator;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int NUM_RU = 4;
  localparam int RW     = 2;
  localparam int CW     = 2;
  localparam int UW     = 2;
  localparam int NW     = 5;
  localparam int NPE    = ROWS * COLS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [NPE-1:0]       fault_mat = '0;
  logic                 busy;
  logic                 done;
  logic [NUM_RU-1:0]    ru_valid;
  logic [NUM_RU*RW-1:0] ru_row;
  logic [NUM_RU*CW-1:0] ru_col;
  logic [NW-1:0]        fault_count;
  logic                 overflow;
  logic [RW-1:0]        query_row = '0;
  logic [CW-1:0]        query_col = '0;
  logic                 query_hit;
  logic [UW-1:0]        query_ru;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NUM_RU-1:0]    valid;
    logic [NUM_RU*RW-1:0] row;
    logic [NUM_RU*CW-1:0] col;
    logic [NW-1:0]        cnt;
    logic                 ovf;
  } exp_t;

  exp_t sb[$];

  ru_allocator #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .NUM_RU (NUM_RU)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .fault_mat   (fault_mat),
    .busy        (busy),
    .done        (done),
    .ru_valid    (ru_valid),
    .ru_row      (ru_row),
    .ru_col      (ru_col),
    .fault_count (fault_count),
    .overflow    (overflow),
    .query_row   (query_row),
    .query_col   (query_col),
    .query_hit   (query_hit),
    .query_ru    (query_ru)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference allocation: column-major walk, first NUM_RU faults get RUs in order
  function automatic exp_t model(input logic [NPE-1:0] m);
    exp_t e;
    int   p;
    e.valid = '0;
    e.row   = '0;
    e.col   = '0;
    e.cnt   = '0;
    e.ovf   = 1'b0;
    p       = 0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (m[c*ROWS + r]) begin
          e.cnt = e.cnt + 1'b1;
          if (p < NUM_RU) begin
            e.valid[p]         = 1'b1;
            e.row[p*RW +: RW]  = RW'(r);
            e.col[p*CW +: CW]  = CW'(c);
            p++;
          end else begin
            e.ovf = 1'b1;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_table(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(ru_valid), 32'(e.valid));
    chk({tag, ".row"},   32'(ru_row),   32'(e.row));
    chk({tag, ".col"},   32'(ru_col),   32'(e.col));
    chk({tag, ".count"}, 32'(fault_count), 32'(e.cnt));
    chk({tag, ".ovf"},   32'(overflow), 32'(e.ovf));
  endtask

  task automatic check_query(input string tag, input exp_t e, input int r, input int c);
    logic          eh;
    logic [UW-1:0] er;
    eh = 1'b0;
    er = '0;
    for (int k = 0; k < NUM_RU; k++) begin
      if (!eh && e.valid[k] && e.row[k*RW +: RW] == RW'(r) && e.col[k*CW +: CW] == CW'(c)) begin
        eh = 1'b1;
        er = UW'(k);
      end
    end
    query_row = RW'(r);
    query_col = CW'(c);
    #1;
    chk({tag, ".hit"}, 32'(query_hit), 32'(eh));
    chk({tag, ".ru"},  32'(query_ru),  32'(er));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".valid"}, 32'(ru_valid), 32'd0);
    chk({tag, ".row"},   32'(ru_row), 32'd0);
    chk({tag, ".col"},   32'(ru_col), 32'd0);
    chk({tag, ".count"}, 32'(fault_count), 32'd0);
    chk({tag, ".ovf"},   32'(overflow), 32'd0);
    query_row = '0;
    query_col = '0;
    #1;
    chk({tag, ".qhit"},  32'(query_hit), 32'd0);
    chk({tag, ".qru"},   32'(query_ru), 32'd0);
  endtask

  // One full pass; n counts cycles after the cycle in which start was driven
  task automatic run_pass(input logic [NPE-1:0] m, input string tag, input bit interfere);
    int   lat;
    int   dones;
    exp_t e;
    lat   = -1;
    dones = 0;
    fault_mat = m;
    start     = 1'b1;
    sb.push_back(model(m));
    for (int n = 1; n <= 22; n++) begin
      step();
      start = 1'b0;
      if (interfere && n == 3) fault_mat = '1;
      if (interfere && n == 5) start = 1'b1;
      if (n == 8) begin
        query_row = '0;
        query_col = '0;
        #1;
        chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
        chk({tag, ".qhit_busy"}, 32'(query_hit), 32'd0);
      end
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = n;
          chk({tag, ".sb_avail"}, 32'(sb.size()), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_table({tag, ".at_done"}, e);
          end
        end
      end
      if (lat > 0 && n == lat + 1) begin
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        chk({tag, ".done_after"}, 32'(done), 32'd0);
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(NPE + 1));
    chk({tag, ".done_pulses"}, 32'(dones), 32'd1);
    check_table({tag, ".hold"}, model(m));
  endtask

  initial begin
    exp_t e;
    int   dones;

    // Reset and idle
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_zero("reset");

    // Single fault at PE (0,0)
    run_pass(16'h0001, "one", 1'b0);
    e = model(16'h0001);
    check_query("one.q00", e, 0, 0);
    check_query("one.q10", e, 1, 0);

    // Two faults, r1c1 and r2c2
    run_pass(16'h0420, "two", 1'b0);
    e = model(16'h0420);
    check_query("two.q22", e, 2, 2);
    check_query("two.q33", e, 3, 3);
    check_query("two.q11", e, 1, 1);

    // Six faults: first four mapped, overflow flagged
    run_pass(16'h003F, "six", 1'b0);
    e = model(16'h003F);
    check_query("six.q30", e, 3, 0);
    check_query("six.q01", e, 0, 1);

    // No faults: full scan, empty table
    run_pass(16'h0000, "zero", 1'b0);

    // Every PE faulty: count reaches its ceiling
    run_pass(16'hFFFF, "all", 1'b0);

    // Matrix change and extra start during the pass must not disturb it
    run_pass(16'h8001, "intf", 1'b1);
    e = model(16'h8001);
    check_query("intf.q33", e, 3, 3);

    // Reset mid-pass: everything clears, no done pulse
    fault_mat = 16'h0FF0;
    start     = 1'b1;
    dones     = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      start = 1'b0;
      if (done) dones++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("midrst");
    for (int n = 0; n < 20; n++) begin
      step();
      if (done) dones++;
    end
    chk("midrst.no_done", 32'(dones), 32'd0);

    // Fresh pass after the aborted one
    run_pass(16'hA005, "fresh", 1'b0);
    e = model(16'hA005);
    check_query("fresh.q31", e, 3, 1);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
